// File: rtl/add_arb_pkg.sv
// Shared constants, helpers and response record for the fp16 adder arbiter.
package add_arb_pkg;

  localparam int FP16_W = 16;

  // Requester-ID width: $clog2 of the requester count, never below one bit.
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Response record at the default configuration (4 requesters, 23-bit info).
  // The top builds the same layout from its own parameters.
  typedef struct packed {
    logic [0:0]        id_msb;
    logic [0:0]        id_lsb;
    logic [22:0]       info;
    logic [FP16_W-1:0] sum;
  } rsp_default_t;

endpackage

// File: rtl/add_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the priority pointer.
module rr_arbiter
  import add_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_w(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id
);

  logic [ID_W-1:0] ptr;
  int              best;
  int              best_dist;
  logic            found;

  // Distance of requester i from the pointer, counting upward with wrap-around.
  function automatic int dist_of(input int i, input int p);
    int d;
    d = i - p;
    if (d < 0) d += NUM_REQ;
    return d;
  endfunction

  // NOTE: every variable written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    best      = 0;
    best_dist = NUM_REQ;
    found     = 1'b0;
    gnt       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (en && req[i] && (dist_of(i, int'(ptr)) < best_dist)) begin
        best_dist = dist_of(i, int'(ptr));
        best      = i;
        found     = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt[i] = found && (i == best);
    end
    gnt_id = ID_W'(best);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
    end
  end

endmodule

// File: rtl/add_arbiter.sv
// Shares one combinational fp16 adder among NUM_REQ requesters with a registered response.
// Optional perf counters are built when ADD_ARB_PERF_EN is defined.
module add_arbiter
  import add_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int INFO_WIDTH = 23,
  localparam int ID_W       = id_w(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_vld,
  output logic [NUM_REQ-1:0]            req_rdy,
  input  logic [NUM_REQ*FP16_W-1:0]     req_data0,
  input  logic [NUM_REQ*FP16_W-1:0]     req_data1,
  input  logic [NUM_REQ*INFO_WIDTH-1:0] req_info,
  output logic                          add_in_vld,
  output logic [FP16_W-1:0]             add_data0,
  output logic [FP16_W-1:0]             add_data1,
  output logic [INFO_WIDTH+ID_W-1:0]    add_info_in,
  input  logic                          add_out_vld,
  input  logic [INFO_WIDTH+ID_W-1:0]    add_info_out,
  input  logic [FP16_W-1:0]             add_sum,
  output logic                          rsp_vld,
  input  logic                          rsp_rdy,
  output logic [ID_W-1:0]               rsp_id,
  output logic [INFO_WIDTH-1:0]         rsp_info,
  output logic [FP16_W-1:0]             rsp_sum
`ifdef ADD_ARB_PERF_EN
  ,
  output logic [31:0]                   perf_op_cnt,
  output logic [31:0]                   perf_stall_cnt
`endif
);

  typedef struct packed {
    logic [ID_W-1:0]       id;
    logic [INFO_WIDTH-1:0] info;
    logic [FP16_W-1:0]     sum;
  } rsp_t;

  logic               can_issue;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_id;
  logic [INFO_WIDTH-1:0] gnt_info;
  rsp_t               rsp_q;

  // The response slot is free when empty or being drained this cycle.
  assign can_issue = !rsp_vld || rsp_rdy;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req_vld),
    .en     (can_issue),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign req_rdy    = gnt;
  assign add_in_vld = |(req_vld & req_rdy);

  always_comb begin
    add_data0 = '0;
    add_data1 = '0;
    gnt_info  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        add_data0 = req_data0[FP16_W*i +: FP16_W];
        add_data1 = req_data1[FP16_W*i +: FP16_W];
        gnt_info  = req_info[INFO_WIDTH*i +: INFO_WIDTH];
      end
    end
  end

  assign add_info_in = add_in_vld ? {gnt_id, gnt_info} : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_vld <= 1'b0;
      rsp_q   <= '0;
    end else if (add_out_vld) begin
      rsp_vld    <= 1'b1;
      rsp_q.id   <= add_info_out[INFO_WIDTH +: ID_W];
      rsp_q.info <= add_info_out[INFO_WIDTH-1:0];
      rsp_q.sum  <= add_sum;
    end else if (rsp_rdy) begin
      rsp_vld <= 1'b0;
    end
  end

  assign rsp_id   = rsp_q.id;
  assign rsp_info = rsp_q.info;
  assign rsp_sum  = rsp_q.sum;

`ifdef ADD_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_op_cnt    <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (add_in_vld)              perf_op_cnt    <= perf_op_cnt + 32'd1;
      if (|req_vld && !can_issue)  perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`else
  // Counters and their ports are omitted in this build.
`endif

`ifndef SYNTHESIS
  a_rdy_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_rdy));
  a_rsp_stable  : assert property (@(posedge clk) disable iff (!rst_n)
                    (rsp_vld && !rsp_rdy) |=> (rsp_vld && $stable(rsp_q)));
`endif

endmodule

// File: tb/tb_add_arbiter.sv
// Self-checking bench for add_arbiter with a behavioural fp16 adder stand-in.
module tb_add_arbiter;

  localparam int N    = 4;
  localparam int IW   = 23;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req_vld = '0;
  logic [N-1:0]      req_rdy;
  logic [N*16-1:0]   req_data0 = '0;
  logic [N*16-1:0]   req_data1 = '0;
  logic [N*IW-1:0]   req_info = '0;
  logic              add_in_vld;
  logic [15:0]       add_data0, add_data1;
  logic [IW+IDW-1:0] add_info_in;
  logic              add_out_vld;
  logic [IW+IDW-1:0] add_info_out;
  logic [15:0]       add_sum;
  logic              rsp_vld;
  logic              rsp_rdy = 1'b0;
  logic [IDW-1:0]    rsp_id;
  logic [IW-1:0]     rsp_info;
  logic [15:0]       rsp_sum;
`ifdef ADD_ARB_PERF_EN
  logic [31:0]       perf_op_cnt, perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  add_arbiter #(.NUM_REQ(N), .INFO_WIDTH(IW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_vld      (req_vld),
    .req_rdy      (req_rdy),
    .req_data0    (req_data0),
    .req_data1    (req_data1),
    .req_info     (req_info),
    .add_in_vld   (add_in_vld),
    .add_data0    (add_data0),
    .add_data1    (add_data1),
    .add_info_in  (add_info_in),
    .add_out_vld  (add_out_vld),
    .add_info_out (add_info_out),
    .add_sum      (add_sum),
    .rsp_vld      (rsp_vld),
    .rsp_rdy      (rsp_rdy),
    .rsp_id       (rsp_id),
    .rsp_info     (rsp_info),
    .rsp_sum      (rsp_sum)
`ifdef ADD_ARB_PERF_EN
    ,
    .perf_op_cnt    (perf_op_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  // Adder for positive normal operands: align, add, renormalise, truncate.
  function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
    int ea, eb, ma, mb, t, s;
    ea = int'(a[14:10]); eb = int'(b[14:10]);
    ma = 1024 + int'(a[9:0]); mb = 1024 + int'(b[9:0]);
    if (ea < eb) begin
      t = ea; ea = eb; eb = t;
      t = ma; ma = mb; mb = t;
    end
    mb = (ea - eb > 11) ? 0 : (mb >> (ea - eb));
    s = ma + mb;
    if (s >= 2048) begin
      s = s >> 1;
      ea = ea + 1;
    end
    return {1'b0, ea[4:0], s[9:0]};
  endfunction

  assign add_out_vld  = add_in_vld;
  assign add_info_out = add_info_in;
  assign add_sum      = fp16_add(add_data0, add_data1);

  function automatic logic [15:0] rand_fp16();
    return {1'b0, 5'($urandom_range(1, 29)), 10'($urandom)};
  endfunction

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: priority pointer, response slot and op/stall tallies.
  logic [15:0] d0 [N];
  logic [15:0] d1 [N];
  logic [IW-1:0] inf [N];
  int          m_ptr;
  bit          m_vld;
  int          m_id;
  logic [IW-1:0] m_info;
  logic [15:0] m_sum;
  int          m_ops, m_stalls;

  task automatic model_reset();
    m_ptr = 0; m_vld = 0; m_id = 0; m_info = '0; m_sum = '0;
    m_ops = 0; m_stalls = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_vld = '0; rsp_rdy = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // One clock: drive at negedge, check combinational grant, then the registered response.
  task automatic cycle(input logic [N-1:0] vld, input logic rdy, output logic [N-1:0] seen);
    bit can;
    int g;
    logic [N-1:0] exp_rdy;
    req_vld = vld;
    rsp_rdy = rdy;
    for (int i = 0; i < N; i++) begin
      req_data0[16*i +: 16] = d0[i];
      req_data1[16*i +: 16] = d1[i];
      req_info[IW*i +: IW]  = inf[i];
    end
    #1;
    can = !m_vld || rdy;
    g = -1;
    if (can) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && vld[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
    end
    exp_rdy = (g >= 0) ? N'(1 << g) : '0;
    seen = req_rdy;
    check("req_rdy", req_rdy, exp_rdy);
    check("add_in_vld", add_in_vld, (g >= 0));
    if (g >= 0) m_ops++;
    if (|vld && !can) m_stalls++;
    @(posedge clk);
    #1;
    if (g >= 0) begin
      m_vld = 1; m_id = g; m_info = inf[g]; m_sum = fp16_add(d0[g], d1[g]);
      m_ptr = (g + 1) % N;
    end else if (rdy) begin
      m_vld = 0;
    end
    check("rsp_vld", rsp_vld, m_vld);
    if (m_vld) begin
      check("rsp_id", rsp_id, m_id);
      check("rsp_info", rsp_info, m_info);
      check("rsp_sum", rsp_sum, m_sum);
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic [N-1:0] vld;
    logic         rdy;
    logic [N-1:0] exp_rdy;
    logic         exp_vld;
    int           exp_id;
  } vec_t;

  vec_t tbl [17];
  logic [N-1:0] seen;
  logic [N-1:0] rv;
  bit hold [N];

  initial begin
    // Fairness, wrap/skip, backpressure and drain, expressed as per-cycle expectations.
    for (int i = 0; i < 8; i++) tbl[i] = '{4'b1111, 1'b1, N'(1 << (i % 4)), 1'b1, i % 4};
    tbl[8]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2};
    tbl[9]  = '{4'b0101, 1'b1, 4'b0001, 1'b1, 0};
    tbl[10] = '{4'b0101, 1'b1, 4'b0100, 1'b1, 2};
    tbl[11] = '{4'b0010, 1'b0, 4'b0000, 1'b1, 2};
    tbl[12] = '{4'b0010, 1'b0, 4'b0000, 1'b1, 2};
    tbl[13] = '{4'b0010, 1'b1, 4'b0010, 1'b1, 1};
    tbl[14] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 0};
    tbl[15] = '{4'b1000, 1'b0, 4'b1000, 1'b1, 3};
    tbl[16] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 0};

    for (int i = 0; i < N; i++) begin
      d0[i] = rand_fp16(); d1[i] = rand_fp16(); inf[i] = IW'($urandom);
    end

    do_reset();
    check("reset_rsp_vld", rsp_vld, 0);
    check("reset_rsp_id", rsp_id, 0);
    check("reset_rsp_info", rsp_info, 0);
    check("reset_rsp_sum", rsp_sum, 0);
    check("reset_req_rdy", req_rdy, 0);

    // Single request: 1.0 + 2.0 = 3.0.
    d0[0] = 16'h3C00; d1[0] = 16'h4000; inf[0] = 23'h12345;
    cycle(4'b0001, 1'b1, seen);
    check("single_vld", rsp_vld, 1);
    check("single_id", rsp_id, 0);
    check("single_sum", rsp_sum, 16'h4200);
    check("single_info", rsp_info, 23'h12345);

    // Reset while a response is pending: valid must drop without a clock edge.
    cycle(4'b0001, 1'b0, seen);
    check("pre_reset_vld", rsp_vld, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_vld", rsp_vld, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cycle(4'b1111, 1'b1, seen);
    check("post_reset_first_grant", seen, 4'b0001);

    do_reset();
    foreach (tbl[i]) begin
      cycle(tbl[i].vld, tbl[i].rdy, seen);
      check("tbl_rdy", seen, tbl[i].exp_rdy);
      check("tbl_vld", rsp_vld, tbl[i].exp_vld);
      if (tbl[i].exp_vld) check("tbl_id", rsp_id, tbl[i].exp_id);
    end

`ifdef ADD_ARB_PERF_EN
    do_reset();
    for (int i = 0; i < 10; i++) cycle(4'b0001, 1'b1, seen);
    for (int i = 0; i < 3; i++) cycle(4'b0001, 1'b0, seen);
    check("perf_op_cnt", perf_op_cnt, 10);
    check("perf_stall_cnt", perf_stall_cnt, 3);
`endif

    // Randomised traffic; a requester left waiting keeps its request and payload.
    do_reset();
    for (int i = 0; i < N; i++) hold[i] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (hold[i]) begin
          rv[i] = 1'b1;
        end else begin
          d0[i] = rand_fp16(); d1[i] = rand_fp16(); inf[i] = IW'($urandom);
          rv[i] = 1'($urandom_range(0, 1));
        end
      end
      cycle(rv, ($urandom_range(0, 3) != 0), seen);
      for (int i = 0; i < N; i++) hold[i] = rv[i] && !seen[i];
    end
`ifdef ADD_ARB_PERF_EN
    check("rand_perf_op_cnt", perf_op_cnt, m_ops);
    check("rand_perf_stall_cnt", perf_stall_cnt, m_stalls);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
